// File: rtl/cpu_alu_seq.sv
// Sequencer and arbiter for the shared 8-bit CPU ALU: serves 8-bit add/sub for the
// execute unit and a 16-bit increment (one or two inc_A passes) for the address unit.
module cpu_alu_seq #(
    parameter int ARB_MODE  = 1,
    parameter int PAGE_WRAP = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_req,
    input  logic        ex_op,
    input  logic [7:0]  ex_a,
    input  logic [7:0]  ex_b,
    output logic        ex_done,
    output logic [7:0]  ex_result,
    input  logic        ad_req,
    input  logic [15:0] ad_addr,
    output logic        ad_done,
    output logic [15:0] ad_result,
    output logic        alu_add,
    output logic        alu_sub,
    output logic        alu_inc_A,
    output logic [7:0]  alu_A,
    output logic [7:0]  alu_B,
    input  logic [7:0]  alu_out,
    output logic        busy
);

    typedef enum logic [2:0] {IDLE, EXEC, INC_LO, INC_HI, DONE} state_t;

    state_t      state_q;
    logic        latOp_q;
    logic [7:0]  latA_q;
    logic [7:0]  latB_q;
    logic [15:0] latAddr_q;
    logic        prefEx_q;
    logic        exDone_q;
    logic        adDone_q;
    logic [7:0]  exResult_q;
    logic [15:0] adResult_q;
    logic        grantEx;
    logic        grantAd;

    // prefEx_q remembers which side was not granted last, for round-robin ties.
    always_comb begin
        grantEx = 1'b0;
        grantAd = 1'b0;
        if (ex_req && ad_req) begin
            if (ARB_MODE == 0 || prefEx_q) grantEx = 1'b1;
            else                           grantAd = 1'b1;
        end else if (ex_req) begin
            grantEx = 1'b1;
        end else if (ad_req) begin
            grantAd = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            latOp_q    <= 1'b0;
            latA_q     <= 8'h00;
            latB_q     <= 8'h00;
            latAddr_q  <= 16'h0000;
            prefEx_q   <= 1'b1;
            exDone_q   <= 1'b0;
            adDone_q   <= 1'b0;
            exResult_q <= 8'h00;
            adResult_q <= 16'h0000;
        end else begin
            exDone_q <= 1'b0;
            adDone_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grantEx) begin
                        latOp_q  <= ex_op;
                        latA_q   <= ex_a;
                        latB_q   <= ex_b;
                        prefEx_q <= 1'b0;
                        state_q  <= EXEC;
                    end else if (grantAd) begin
                        latAddr_q <= ad_addr;
                        prefEx_q  <= 1'b1;
                        state_q   <= INC_LO;
                    end
                end
                EXEC: begin
                    exResult_q <= alu_out;
                    exDone_q   <= 1'b1;
                    state_q    <= DONE;
                end
                INC_LO: begin
                    adResult_q[7:0] <= alu_out;
                    // A low-byte rollover needs a second pass over the high byte.
                    if (alu_out == 8'h00 && PAGE_WRAP == 0) begin
                        state_q <= INC_HI;
                    end else begin
                        adResult_q[15:8] <= latAddr_q[15:8];
                        adDone_q         <= 1'b1;
                        state_q          <= DONE;
                    end
                end
                INC_HI: begin
                    adResult_q[15:8] <= alu_out;
                    adDone_q         <= 1'b1;
                    state_q          <= DONE;
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // ALU drive depends only on state and latched operands, never on live inputs.
    always_comb begin
        alu_add   = 1'b0;
        alu_sub   = 1'b0;
        alu_inc_A = 1'b0;
        alu_A     = 8'h00;
        alu_B     = 8'h00;
        case (state_q)
            EXEC: begin
                alu_A   = latA_q;
                alu_B   = latB_q;
                alu_add = ~latOp_q;
                alu_sub = latOp_q;
            end
            INC_LO: begin
                alu_A     = latAddr_q[7:0];
                alu_inc_A = 1'b1;
            end
            INC_HI: begin
                alu_A     = latAddr_q[15:8];
                alu_inc_A = 1'b1;
            end
            default: ;
        endcase
    end

    assign ex_done   = exDone_q;
    assign ad_done   = adDone_q;
    assign ex_result = exResult_q;
    assign ad_result = adResult_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: doc/cpu_alu_seq.md
Name: cpu_alu_seq

Overview:
- Sequencer and arbiter for the single shared 8-bit CPU ALU (add, sub, inc_A controls; A/B operands; combinational out).
- Two requesters share the ALU:
  - the execute unit, which needs 8-bit add/sub;
  - the address unit, which needs a 16-bit increment built from up to two 8-bit inc_A passes.
- The block owns every ALU control and operand input, latches ALU results, and returns them through per-requester req/done handshakes.

Parameters:
ARB_MODE, 1, 0 = fixed priority to execute unit; 1 = round-robin between requesters
PAGE_WRAP, 0, 1 = 16-bit increment never carries into the high byte (addr_hi preserved)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous active-high reset
ex_req  in  1  execute request, level, held until ex_done
ex_op  in  1  0 = add, 1 = sub
ex_a  in  8  execute operand, drives ALU A
ex_b  in  8  execute operand, drives ALU B
ex_done  out  1  one-cycle pulse, ex_result valid
ex_result  out  8  registered execute result
ad_req  in  1  address-increment request, level, held until ad_done
ad_addr  in  16  address to increment
ad_done  out  1  one-cycle pulse, ad_result valid
ad_result  out  16  registered incremented address
alu_add  out  1  to ALU add
alu_sub  out  1  to ALU sub
alu_inc_A  out  1  to ALU inc_A
alu_A  out  8  to ALU A
alu_B  out  8  to ALU B
alu_out  in  8  from ALU out (combinational)
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, immediate):
  - state = IDLE; ex_done = ad_done = 0; ex_result = 0x00; ad_result = 0x0000.
  - Round-robin pointer favours execute; operand latches = 0.
  - An in-flight operation is discarded and no done pulse is issued.
- States: IDLE, EXEC, INC_LO, INC_HI, DONE.
- ALU drive (decoded from state, uses latched operands only):
  - IDLE/DONE: add = sub = inc_A = 0; A = B = 0x00.
  - EXEC: A = lat_a, B = lat_b; add = ~lat_op, sub = lat_op.
  - INC_LO: A = lat_addr[7:0], inc_A = 1.
  - INC_HI: A = lat_addr[15:8], inc_A = 1.
  - At most one of add/sub/inc_A is high at any time.
- IDLE arbitration, sampled on the rising edge:
  - Only ex_req high: grant execute, latch ex_op/ex_a/ex_b, go to EXEC.
  - Only ad_req high: grant address, latch ad_addr, go to INC_LO.
  - Both high, ARB_MODE = 0: execute wins.
  - Both high, ARB_MODE = 1: the requester not granted last wins; the pointer updates on every grant.
- EXEC: at the edge, ex_result <= alu_out and ex_done <= 1; go to DONE.
  - add result = (a + b) mod 256.
  - sub result = (b - a) mod 256 (ALU convention).
- INC_LO: at the edge, ad_result[7:0] <= alu_out.
  - If alu_out == 0x00 and PAGE_WRAP = 0: go to INC_HI.
  - Otherwise: ad_result[15:8] <= lat_addr[15:8], ad_done <= 1, go to DONE.
- INC_HI: at the edge, ad_result[15:8] <= alu_out and ad_done <= 1; go to DONE. 0xFFFF wraps to 0x0000.
- DONE:
  - The done pulse is high for exactly this cycle and req inputs are ignored.
  - The requester must drop req by the edge ending DONE.
  - The next edge clears done and returns to IDLE; arbitration resumes the following edge.
- Latency, measured as cycles from the grant edge to the first done-high cycle: execute 1; increment 1 without carry, 2 with carry.
- Results hold their value until the next completion for the same requester.
- Operand inputs may change after the grant without affecting the operation in progress.
- busy = 1 in EXEC, INC_LO, INC_HI and DONE.
- A req dropped mid-operation does not abort the operation; the done pulse is still issued.

Test Plan:
- Reset then ex_req, op = 0, a = 0x3C, b = 0x14 -> ex_done pulse exactly 1 cycle after grant edge, ex_result = 0x50; ALU controls 0 in IDLE.
- ex_req, op = 1, a = 0x05, b = 0x03 -> ex_result = 0xFE (b - a wrap); alu_sub high only in EXEC.
- ad_req, addr = 0x12FF -> INC_LO then INC_HI, ad_result = 0x1300 after 2 ALU cycles. addr = 0x1234 -> 0x1235 after 1 ALU cycle. addr = 0xFFFF -> 0x0000. PAGE_WRAP = 1, addr = 0x12FF -> 0x1200.
- Both req high continuously (ack by dropping and re-raising):
  - ARB_MODE = 1: grants alternate ex, ad, ex, ad.
  - ARB_MODE = 0: execute always wins while both are asserted.
- rst asserted during INC_HI -> outputs return to reset values asynchronously, no ad_done; a fresh request after release completes normally.
- Requester holds req through DONE and drops it on the edge ending DONE -> no duplicate grant; ex_a changed after grant -> ex_result still reflects the latched operands.
